// File: rtl/door_blink_ctrl.sv
// door_blink_ctrl: N_CH door-open indicators sharing one blink prescaler.
// Ports: CLK, RST_N (async low), door_open[N_CH], abort -> light, busy, any_busy.
// Optional hold-while-open mode: define DOOR_HOLD_EN.
module door_blink_ctrl #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 25000000,
  parameter int HALF_PERIODS = 20
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] door_open,
  input  logic            abort,
  output logic [N_CH-1:0] light,
  output logic [N_CH-1:0] busy,
  output logic            any_busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(HALF_PERIODS);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLINK,
    S_HOLD
  } state_t;

  state_t          r_state [N_CH];
  logic [CW-1:0]   r_cnt   [N_CH];
  logic [PW-1:0]   r_pre;
  logic [N_CH-1:0] r_prev;
  logic [N_CH-1:0] r_light;
  logic [N_CH-1:0] r_busy;

  logic            w_tick;
  logic [N_CH-1:0] w_rise;

  assign w_tick = (r_pre == PRE_LAST);
  assign w_rise = door_open & ~r_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre  <= '0;
      r_prev <= '0;
    end else begin
      r_pre  <= w_tick ? '0 : r_pre + 1'b1;
      r_prev <= door_open;
    end
  end

  // abort beats rise, rise beats tick; a rise always restarts at count 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_light <= '0;
      r_busy  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (abort) begin
          r_state[i] <= S_IDLE;
          r_light[i] <= 1'b0;
          r_cnt[i]   <= '0;
          r_busy[i]  <= 1'b0;
        end else if (w_rise[i]) begin
`ifdef DOOR_HOLD_EN
          r_state[i] <= S_HOLD;
`else
          r_state[i] <= S_BLINK;
`endif
          r_light[i] <= 1'b1;
          r_cnt[i]   <= '0;
          r_busy[i]  <= 1'b1;
        end else begin
          case (r_state[i])
            S_BLINK: begin
              if (w_tick) begin
                if (r_cnt[i] == CNT_LAST) begin
                  r_state[i] <= S_IDLE;
                  r_light[i] <= 1'b0;
                  r_cnt[i]   <= '0;
                  r_busy[i]  <= 1'b0;
                end else begin
                  r_light[i] <= ~r_light[i];
                  r_cnt[i]   <= r_cnt[i] + 1'b1;
                end
              end
            end
`ifdef DOOR_HOLD_EN
            // door closed: start the normal sequence from the lit phase
            S_HOLD: begin
              if (!door_open[i]) begin
                r_state[i] <= S_BLINK;
                r_light[i] <= 1'b1;
                r_cnt[i]   <= '0;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign light    = r_light;
  assign busy     = r_busy;
  assign any_busy = |r_busy;

endmodule

// File: tb/tb_door_blink_ctrl.sv
// tb_door_blink_ctrl: vector table, directed corner sequences and
// random stimulus against a tick-counting reference model.
module tb_door_blink_ctrl;

  localparam int NC = 4;
  localparam int TD = 4;
  localparam int HP = 6;
`ifdef DOOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          CLK;
  logic          RST_N;
  logic [NC-1:0] door_open;
  logic          abort;
  logic [NC-1:0] light;
  logic [NC-1:0] busy;
  logic          any_busy;

  door_blink_ctrl #(
    .N_CH(NC), .TICK_DIV(TD), .HALF_PERIODS(HP)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .door_open(door_open), .abort(abort),
    .light(light), .busy(busy), .any_busy(any_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // model: ticks elapsed since trigger decide the light phase
  int          m_edges;
  bit          m_tick;
  bit          m_act  [NC];
  bit          m_hold [NC];
  bit          m_prev [NC];
  int          m_k    [NC];
  logic [NC-1:0] m_light;
  logic [NC-1:0] m_busy;

  task automatic model_reset();
    m_edges = 0;
    m_tick  = 1'b0;
    m_light = '0;
    m_busy  = '0;
    for (int i = 0; i < NC; i++) begin
      m_act[i] = 0; m_hold[i] = 0; m_prev[i] = 0; m_k[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NC-1:0] d, input logic a);
    bit rise;
    m_edges++;
    m_tick = (m_edges % TD) == 0;
    for (int i = 0; i < NC; i++) begin
      rise = d[i] && !m_prev[i];
      m_prev[i] = d[i];
      if (a) begin
        m_act[i] = 0; m_hold[i] = 0; m_k[i] = 0;
      end else if (rise) begin
        m_act[i] = 1; m_hold[i] = HOLD_EN; m_k[i] = 0;
      end else if (m_hold[i]) begin
        if (!d[i]) begin
          m_hold[i] = 0; m_k[i] = 0;
        end
      end else if (m_act[i] && m_tick) begin
        m_k[i]++;
        if (m_k[i] == HP) begin
          m_act[i] = 0; m_k[i] = 0;
        end
      end
      m_light[i] = m_act[i] && (m_hold[i] || (m_k[i] % 2) == 0);
      m_busy[i]  = m_act[i];
    end
  endtask

  task automatic chk(input string nm, input logic [NC-1:0] act,
                     input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [NC-1:0] d, input logic a);
    door_open = d;
    abort     = a;
    @(posedge CLK);
    model_edge(d, a);
    #1;
    checks++;
    if (light !== m_light || busy !== m_busy || any_busy !== |m_busy) begin
      errors++;
      $display("FAIL model: light=%b busy=%b any=%b expected %b %b %b at %0t",
               light, busy, any_busy, m_light, m_busy, |m_busy, $time);
    end
  endtask

  typedef struct {
    logic [NC-1:0] door;
    logic          ab;
    int            n;
    logic [NC-1:0] el;
    logic [NC-1:0] eb;
  } vec_t;

  vec_t tbl [13];
  int   cnt;

  initial begin
    // pulse on ch0: ticks land on edges 4,8,..,24; ch1 rises on tick edge 28
    tbl[0]  = '{4'b0001, 1'b0, 1, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b0000, 1'b0, 2, 4'b0001, 4'b0001};
    tbl[2]  = '{4'b0000, 1'b0, 1, 4'b0000, 4'b0001};
    tbl[3]  = '{4'b0000, 1'b0, 4, 4'b0001, 4'b0001};
    tbl[4]  = '{4'b0000, 1'b0, 4, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0000, 1'b0, 4, 4'b0001, 4'b0001};
    tbl[6]  = '{4'b0000, 1'b0, 4, 4'b0000, 4'b0001};
    tbl[7]  = '{4'b0000, 1'b0, 3, 4'b0000, 4'b0001};
    tbl[8]  = '{4'b0000, 1'b0, 1, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b0, 3, 4'b0000, 4'b0000};
    tbl[10] = '{4'b0010, 1'b0, 1, 4'b0010, 4'b0010};
    tbl[11] = '{4'b0000, 1'b0, 3, 4'b0010, 4'b0010};
    tbl[12] = '{4'b0000, 1'b0, 1, 4'b0000, 4'b0010};

    RST_N = 1'b0;
    door_open = '0;
    abort = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_light", light, '0);
    chk("rst_busy", busy, '0);
    chk("rst_any", {3'b0, any_busy}, '0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[r]) begin
      repeat (tbl[r].n) step(tbl[r].door, tbl[r].ab);
      chk($sformatf("tbl%0d_light", r), light, tbl[r].el);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].eb);
      chk($sformatf("tbl%0d_any", r), {3'b0, any_busy}, {3'b0, |tbl[r].eb});
    end

    // asynchronous reset mid-blink, then first tick 4 edges after release
    step(4'b0001, 1'b0);
    repeat (5) step(4'b0000, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("async_light", light, '0);
    chk("async_busy", busy, '0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    chk("pre_tick_light", light, 4'b0001);
    step(4'b0000, 1'b0);
    chk("first_tick_light", light, 4'b0000);
    chk("first_tick_busy", busy, 4'b0001);

    // retrigger after the 3rd tick: 9 ticks from first trigger to IDLE
    step(4'b0001, 1'b0);
    cnt = 0;
    for (int g = 0; g < 60 && cnt < 3; g++) begin
      step(4'b0000, 1'b0);
      if (m_tick) cnt++;
    end
    chk_int("retrig_pre_ticks", cnt, 3);
    step(4'b0001, 1'b0);
    chk("retrig_light", light, 4'b0001);
    for (int g = 0; g < 100 && busy[0]; g++) begin
      step(4'b0000, 1'b0);
      if (m_tick) cnt++;
    end
    chk_int("retrig_total_ticks", cnt, 9);

    // abort with a simultaneous ch2 rise
    step(4'b0011, 1'b0);
    repeat (5) step(4'b0000, 1'b0);
    chk("pre_abort_busy", busy, 4'b0011);
    step(4'b0100, 1'b1);
    chk("abort_light", light, '0);
    chk("abort_busy", busy, '0);
    step(4'b0100, 1'b0);
    chk("abort_ch2_idle", busy, '0);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    chk("post_abort_ch2", light, 4'b0100);
    step(4'b0000, 1'b0);

    // ch3 held open for 10 ticks, then released
    step(4'b1000, 1'b0);
    cnt = 0;
    for (int g = 0; g < 100 && cnt < 10; g++) begin
      step(4'b1000, 1'b0);
      if (m_tick) cnt++;
    end
    chk("hold_light3", {3'b0, light[3]}, {3'b0, HOLD_EN});
    chk("hold_busy3", {3'b0, busy[3]}, {3'b0, HOLD_EN});
    cnt = 0;
    for (int g = 0; g < 100 && busy[3]; g++) begin
      step(4'b0000, 1'b0);
      if (m_tick) cnt++;
    end
    chk_int("release_ticks", cnt, HOLD_EN ? HP : 0);
    chk("release_busy3", {3'b0, busy[3]}, '0);

    // random door activity with occasional abort
    for (int g = 0; g < 600; g++) begin
      logic [NC-1:0] d;
      d = door_open;
      for (int i = 0; i < NC; i++)
        if ($urandom_range(7) == 0) d[i] = ~d[i];
      step(d, $urandom_range(39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
